// File: rtl/nms_stream_param.sv
// rtl/nms_stream_param.sv - streaming Canny non-maximum suppression with hysteresis classification
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   thr_lo, thr_hi     weak/strong thresholds, captured on the accepted in_sof beat
//   in_valid/in_ready  input handshake; in_sof marks pixel (0,0)
//   in_grad            {mag[MAG_W-1:0], dir[1:0]} in raster order
//   out_valid          output beat (no backpressure) with out_sof/out_eol/out_eof tags
//   out_mag/out_class  suppressed magnitude and 00 none / 01 weak / 10 strong
//   err_sync           one-cycle pulse on a framing error (resync or stray beat in IDLE)
//   busy               high while a frame is running or its last row is being drained
module nms_stream_param #(
    parameter int IMG_W = 1024,
    parameter int IMG_H = 768,
    parameter int MAG_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MAG_W-1:0] thr_lo,
    input  logic [MAG_W-1:0] thr_hi,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [MAG_W+1:0] in_grad,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eol,
    output logic             out_eof,
    output logic [MAG_W-1:0] out_mag,
    output logic [1:0]       out_class,
    output logic             err_sync,
    output logic             busy
);
    localparam int GW = MAG_W + 2;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int PW = $clog2(IMG_W + 2);
    localparam int FW = $clog2(IMG_W + 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [PW-1:0] PRE_FULL   = PW'(IMG_W + 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_W);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;
    state_t state, state_n;

    logic          accept, sof_step, resync, drop, beat_step, flush_step, step;
    logic          last_beat, flush_done;
    logic [GW-1:0] live;
    logic [CW-1:0] col, col_inc, col_nxt, wr_addr, rd_addr;
    logic [RW-1:0] row;
    logic [FW-1:0] flush_cnt;
    logic [MAG_W-1:0] thr_lo_q, thr_hi_q;

    logic [GW-1:0] lb1_mem [IMG_W];
    logic [GW-1:0] lb2_mem [IMG_W];
    logic [GW-1:0] lb1_q, lb2_q;
    logic [GW-1:0] win [3][3];

    logic [PW-1:0] pre_cnt;
    logic [RW-1:0] prow;
    logic [CW-1:0] pcol;
    logic          s1_valid, s1_border, s1_sof, s1_eol, s1_eof;

    logic [MAG_W-1:0] mag_c, n1, n2, nms_mag;
    logic [1:0]       nms_class;

    // Step decode: every accepted frame beat and every drain cycle advances the window.
    always_comb begin
        accept     = in_valid & in_ready;
        sof_step   = accept & in_sof;
        resync     = sof_step & (state == S_RUN);
        drop       = accept & ~in_sof & (state == S_IDLE);
        beat_step  = accept & (state == S_RUN);
        flush_step = (state == S_FLUSH);
        step       = sof_step | beat_step | flush_step;
        last_beat  = beat_step & ~in_sof & (row == ROW_LAST) & (col == COL_LAST);
        flush_done = flush_step & (flush_cnt == FLUSH_LAST);
        live       = flush_step ? '0 : in_grad;
        col_inc    = (col == COL_LAST) ? '0 : col + 1'b1;
        col_nxt    = sof_step ? CW'(1) : col_inc;
        wr_addr    = sof_step ? '0 : col;
        // The RAM output must already hold the next step's column when that step arrives.
        rd_addr    = step ? col_nxt : col;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (sof_step)   state_n = S_RUN;
            S_RUN:   if (last_beat)  state_n = S_FLUSH;
            S_FLUSH: if (flush_done) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state != S_FLUSH);
        busy     = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            flush_cnt <= '0;
            thr_lo_q  <= '0;
            thr_hi_q  <= '0;
        end else begin
            if (step) col <= col_nxt;
            if (sof_step) begin
                row      <= '0;
                thr_lo_q <= thr_lo;
                thr_hi_q <= thr_hi;
            end else if (beat_step && col == COL_LAST && row != ROW_LAST) begin
                row <= row + 1'b1;
            end
            if (flush_step) flush_cnt <= flush_done ? '0 : flush_cnt + 1'b1;
            else            flush_cnt <= '0;
        end
    end

    // Line buffers: lb1 holds the previous row, lb2 the one before it.
    always_ff @(posedge clk) begin
        if (step) begin
            lb1_mem[wr_addr] <= live;
            lb2_mem[wr_addr] <= lb1_q;
        end
        lb1_q <= lb1_mem[rd_addr];
        lb2_q <= lb2_mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
        end else if (step) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb2_q;
            win[1][2] <= lb1_q;
            win[2][2] <= live;
        end
    end

    // Window centre lags the live input by IMG_W+1 steps; track its coordinates separately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            prow      <= '0;
            pcol      <= '0;
            s1_valid  <= 1'b0;
            s1_border <= 1'b0;
            s1_sof    <= 1'b0;
            s1_eol    <= 1'b0;
            s1_eof    <= 1'b0;
        end else begin
            s1_valid <= 1'b0;
            if (sof_step) begin
                pre_cnt <= PW'(1);
                prow    <= '0;
                pcol    <= '0;
            end else if (step) begin
                if (pre_cnt != PRE_FULL) begin
                    pre_cnt <= pre_cnt + 1'b1;
                end else begin
                    s1_valid  <= 1'b1;
                    s1_border <= (prow == '0) || (prow == ROW_LAST) ||
                                 (pcol == '0) || (pcol == COL_LAST);
                    s1_sof    <= (prow == '0) && (pcol == '0);
                    s1_eol    <= (pcol == COL_LAST);
                    s1_eof    <= (prow == ROW_LAST) && (pcol == COL_LAST);
                    if (pcol == COL_LAST) begin
                        pcol <= '0;
                        prow <= (prow == ROW_LAST) ? '0 : prow + 1'b1;
                    end else begin
                        pcol <= pcol + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        mag_c = win[1][1][GW-1:2];
        n1    = '0;
        n2    = '0;
        case (win[1][1][1:0])
            2'b00: begin n1 = win[1][0][GW-1:2]; n2 = win[1][2][GW-1:2]; end
            2'b01: begin n1 = win[0][2][GW-1:2]; n2 = win[2][0][GW-1:2]; end
            2'b10: begin n1 = win[0][1][GW-1:2]; n2 = win[2][1][GW-1:2]; end
            default: begin n1 = win[0][0][GW-1:2]; n2 = win[2][2][GW-1:2]; end
        endcase
        // Ties keep the centre; border pixels are forced to zero regardless.
        if (s1_border || mag_c < n1 || mag_c < n2) nms_mag = '0;
        else                                       nms_mag = mag_c;
        if (nms_mag == '0)            nms_class = 2'b00;
        else if (nms_mag >= thr_hi_q) nms_class = 2'b10;
        else if (nms_mag >= thr_lo_q) nms_class = 2'b01;
        else                          nms_class = 2'b00;
    end

    // A resync discards the old frame's pixel that would otherwise land on this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            out_mag   <= '0;
            out_class <= 2'b00;
            err_sync  <= 1'b0;
        end else begin
            out_valid <= s1_valid & ~resync;
            out_sof   <= s1_valid & ~resync & s1_sof;
            out_eol   <= s1_valid & ~resync & s1_eol;
            out_eof   <= s1_valid & ~resync & s1_eof;
            out_mag   <= (s1_valid & ~resync) ? nms_mag : '0;
            out_class <= (s1_valid & ~resync) ? nms_class : 2'b00;
            err_sync  <= resync | drop;
        end
    end
endmodule

// File: tb/tb_nms_stream_param.sv
// tb/tb_nms_stream_param.sv - directed self-checking bench for nms_stream_param
module tb_nms_stream_param;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int MW = 12;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [MW-1:0] thr_lo = '0;
    logic [MW-1:0] thr_hi = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_sof = 1'b0;
    logic [MW+1:0] in_grad = '0;
    logic          out_valid, out_sof, out_eol, out_eof;
    logic [MW-1:0] out_mag;
    logic [1:0]    out_class;
    logic          err_sync, busy;

    nms_stream_param #(.IMG_W(W), .IMG_H(H), .MAG_W(MW)) dut (
        .clk(clk), .rst_n(rst_n), .thr_lo(thr_lo), .thr_hi(thr_hi),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_grad(in_grad),
        .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .out_mag(out_mag), .out_class(out_class), .err_sync(err_sync), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    logic [16:0] cap_vec[$];
    int          cap_cyc[$];
    int          acc_cyc[$];
    int          err_cyc[$];

    always @(negedge clk) begin
        if (out_valid) begin
            cap_vec.push_back({out_mag, out_class, out_sof, out_eol, out_eof});
            cap_cyc.push_back(cyc);
        end
        if (rst_n && in_valid && in_ready) acc_cyc.push_back(cyc);
        if (err_sync) err_cyc.push_back(cyc);
    end

    logic [MW-1:0] img_mag[N];
    logic [1:0]    img_dir[N];
    logic [MW-1:0] exp_mag[N];
    logic [1:0]    exp_cls[N];

    task automatic clear_caps();
        cap_vec.delete();
        cap_cyc.delete();
        acc_cyc.delete();
        err_cyc.delete();
    endtask

    function automatic bit is_border(int p);
        return (p / W == 0) || (p / W == H - 1) || (p % W == 0) || (p % W == W - 1);
    endfunction

    function automatic logic [16:0] exp_vec(int p);
        logic s, l, e;
        s = (p == 0);
        l = (p % W == W - 1);
        e = (p == N - 1);
        return {exp_mag[p], exp_cls[p], s, l, e};
    endfunction

    // Pixel p comes from step p+W+1; steps past the last beat are consecutive drain cycles.
    function automatic int exp_cyc(int base, int p);
        int k;
        k = p + W + 1;
        if (k < N) return acc_cyc[base + k] + 2;
        return acc_cyc[base + N - 1] + (k - (N - 1)) + 2;
    endfunction

    task automatic fill_uniform(input logic [MW-1:0] m, input logic [1:0] d, input logic [1:0] c);
        for (int p = 0; p < N; p++) begin
            img_mag[p] = m;
            img_dir[p] = d;
            exp_mag[p] = is_border(p) ? '0 : m;
            exp_cls[p] = is_border(p) ? 2'b00 : c;
        end
    endtask

    task automatic put_beat(input logic sof, input logic [MW+1:0] g, output int waits);
        int  t;
        bit  done;
        t = 0;
        done = 0;
        waits = 0;
        in_valid = 1'b1;
        in_sof   = sof;
        in_grad  = g;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1;
            else waits++;
            @(posedge clk);
            #1;
            t++;
            if (!done && t > 100) begin
                n_chk++;
                $display("FAIL beat_timeout: in_ready stayed %0b, required 1 within 100 cycles", in_ready);
                done = 1;
            end
        end
        in_sof = 1'b0;
    endtask

    task automatic drive_frame(input bit gaps, input bit hold, output int first_wait);
        int w;
        first_wait = 0;
        for (int i = 0; i < N; i++) begin
            if (gaps && i > 0) begin
                int g;
                g = int'($urandom_range(0, 2));
                if (g > 0) begin
                    in_valid = 1'b0;
                    repeat (g) begin @(posedge clk); #1; end
                end
            end
            put_beat(i == 0, {img_mag[i], img_dir[i]}, w);
            if (i == 0) first_wait = w;
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int t;
        t = 0;
        while (cap_vec.size() < n && t < 400) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b want 0", out_valid); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0b want 1", in_ready); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else n_pass++;
        n_chk++; if ({err_sync, out_sof, out_eol, out_eof, out_class, out_mag} !== 17'd0)
            $display("FAIL rst_outputs: got %h want 0", {err_sync, out_sof, out_eol, out_eof, out_class, out_mag});
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_frame();
        int w;
        thr_lo = 12'd50;
        thr_hi = 12'd200;
        fill_uniform(12'd100, 2'b00, 2'b01);
        clear_caps();
        drive_frame(0, 0, w);
        wait_out(N);
        n_chk++; if (cap_vec.size() !== N) $display("FAIL frame_count: got %0d want %0d", cap_vec.size(), N); else n_pass++;
        for (int p = 0; p < N && p < cap_vec.size(); p++) begin
            n_chk++; if (cap_vec[p] !== exp_vec(p)) $display("FAIL frame_pix%0d: got %h want %h", p, cap_vec[p], exp_vec(p)); else n_pass++;
            n_chk++; if (cap_cyc[p] !== exp_cyc(0, p)) $display("FAIL frame_lat%0d: got cycle %0d want %0d", p, cap_cyc[p], exp_cyc(0, p)); else n_pass++;
        end
    endtask

    task automatic test_peak();
        int w;
        thr_lo = 12'd50;
        thr_hi = 12'd200;
        for (int d = 0; d < 2; d++) begin
            fill_uniform(12'd100, (d == 0) ? 2'b00 : 2'b10, 2'b01);
            img_mag[11] = 12'd500;
            exp_mag[11] = 12'd500;
            exp_cls[11] = 2'b10;
            if (d == 0) begin
                exp_mag[10] = '0; exp_cls[10] = 2'b00;
                exp_mag[12] = '0; exp_cls[12] = 2'b00;
            end else begin
                exp_mag[19] = '0; exp_cls[19] = 2'b00;
            end
            clear_caps();
            drive_frame(0, 0, w);
            wait_out(N);
            n_chk++; if (cap_vec.size() !== N) $display("FAIL peak%0d_count: got %0d want %0d", d, cap_vec.size(), N); else n_pass++;
            for (int p = 0; p < N && p < cap_vec.size(); p++) begin
                n_chk++; if (cap_vec[p] !== exp_vec(p)) $display("FAIL peak%0d_pix%0d: got %h want %h", d, p, cap_vec[p], exp_vec(p)); else n_pass++;
            end
        end
    endtask

    task automatic test_class();
        int w;
        logic [MW-1:0] cm[W];
        logic [1:0]    cc[W];
        cm = '{12'd100, 12'd40, 12'd50, 12'd199, 12'd200, 12'd100, 12'd100, 12'd100};
        cc = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01};
        for (int f = 0; f < 2; f++) begin
            if (f == 0) begin
                thr_lo = 12'd50;
                thr_hi = 12'd200;
                for (int p = 0; p < N; p++) begin
                    img_mag[p] = cm[p % W];
                    img_dir[p] = 2'b10;
                    exp_mag[p] = is_border(p) ? '0 : cm[p % W];
                    exp_cls[p] = is_border(p) ? 2'b00 : cc[p % W];
                end
            end else begin
                thr_lo = 12'd300;
                thr_hi = 12'd200;
                fill_uniform(12'd250, 2'b00, 2'b10);
            end
            clear_caps();
            drive_frame(0, 0, w);
            thr_lo = 12'd0;
            thr_hi = 12'd0;
            wait_out(N);
            n_chk++; if (cap_vec.size() !== N) $display("FAIL class%0d_count: got %0d want %0d", f, cap_vec.size(), N); else n_pass++;
            for (int p = 0; p < N && p < cap_vec.size(); p++) begin
                n_chk++; if (cap_vec[p] !== exp_vec(p)) $display("FAIL class%0d_pix%0d: got %h want %h", f, p, cap_vec[p], exp_vec(p)); else n_pass++;
            end
        end
    endtask

    task automatic test_flush_hold();
        int w;
        thr_lo = 12'd50;
        thr_hi = 12'd200;
        fill_uniform(12'd100, 2'b00, 2'b01);
        clear_caps();
        drive_frame(0, 1, w);
        drive_frame(1, 0, w);
        n_chk++; if (w !== W + 1) $display("FAIL flush_ready_low: got %0d cycles want %0d", w, W + 1); else n_pass++;
        n_chk++; if (acc_cyc.size() !== 2 * N) $display("FAIL flush_accepts: got %0d want %0d", acc_cyc.size(), 2 * N);
        else begin
            n_pass++;
            n_chk++; if (acc_cyc[N] - acc_cyc[N-1] !== W + 2)
                $display("FAIL flush_sof_gap: got %0d want %0d", acc_cyc[N] - acc_cyc[N-1], W + 2);
            else n_pass++;
        end
        wait_out(2 * N);
        n_chk++; if (cap_vec.size() !== 2 * N) $display("FAIL flush_count: got %0d want %0d", cap_vec.size(), 2 * N); else n_pass++;
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < N && f * N + p < cap_vec.size() && acc_cyc.size() == 2 * N; p++) begin
                n_chk++; if (cap_vec[f*N+p] !== exp_vec(p)) $display("FAIL flush%0d_pix%0d: got %h want %h", f, p, cap_vec[f*N+p], exp_vec(p)); else n_pass++;
                n_chk++; if (cap_cyc[f*N+p] !== exp_cyc(f * N, p)) $display("FAIL flush%0d_lat%0d: got cycle %0d want %0d", f, p, cap_cyc[f*N+p], exp_cyc(f * N, p)); else n_pass++;
            end
        end
    endtask

    task automatic test_resync();
        int w;
        thr_lo = 12'd50;
        thr_hi = 12'd200;
        fill_uniform(12'd100, 2'b00, 2'b01);
        clear_caps();
        for (int i = 0; i < 10; i++) put_beat(i == 0, {12'd700, 2'b00}, w);
        drive_frame(0, 0, w);
        wait_out(N);
        n_chk++; if (err_cyc.size() !== 1) $display("FAIL resync_err_count: got %0d want 1", err_cyc.size()); else n_pass++;
        if (err_cyc.size() > 0 && acc_cyc.size() > 10) begin
            n_chk++; if (err_cyc[0] !== acc_cyc[10] + 1) $display("FAIL resync_err_cycle: got %0d want %0d", err_cyc[0], acc_cyc[10] + 1); else n_pass++;
        end
        n_chk++; if (cap_vec.size() !== N) $display("FAIL resync_count: got %0d want %0d", cap_vec.size(), N); else n_pass++;
        for (int p = 0; p < N && p < cap_vec.size() && acc_cyc.size() == N + 10; p++) begin
            n_chk++; if (cap_vec[p] !== exp_vec(p)) $display("FAIL resync_pix%0d: got %h want %h", p, cap_vec[p], exp_vec(p)); else n_pass++;
            n_chk++; if (cap_cyc[p] !== exp_cyc(10, p)) $display("FAIL resync_lat%0d: got cycle %0d want %0d", p, cap_cyc[p], exp_cyc(10, p)); else n_pass++;
        end
        clear_caps();
        put_beat(1'b0, {12'd100, 2'b00}, w);
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_chk++; if (err_cyc.size() !== 1) $display("FAIL drop_err_count: got %0d want 1", err_cyc.size()); else n_pass++;
        if (err_cyc.size() > 0 && acc_cyc.size() > 0) begin
            n_chk++; if (err_cyc[0] !== acc_cyc[0] + 1) $display("FAIL drop_err_cycle: got %0d want %0d", err_cyc[0], acc_cyc[0] + 1); else n_pass++;
        end
        n_chk++; if (cap_vec.size() !== 0) $display("FAIL drop_outputs: got %0d want 0", cap_vec.size()); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL drop_busy: got %0b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int w;
        thr_lo = 12'd50;
        thr_hi = 12'd200;
        fill_uniform(12'd100, 2'b00, 2'b01);
        for (int m = 0; m < 2; m++) begin
            if (m == 0) begin
                for (int i = 0; i < 15; i++) put_beat(i == 0, {img_mag[i], img_dir[i]}, w);
            end else begin
                drive_frame(0, 0, w);
                repeat (3) @(posedge clk);
                #1;
            end
            rst_n = 1'b0;
            in_valid = 1'b0;
            clear_caps();
            @(negedge clk);
            n_chk++; if ({out_valid, in_ready, busy} !== 3'b010)
                $display("FAIL rstmid%0d_state: got %b want 010", m, {out_valid, in_ready, busy});
            else n_pass++;
            @(negedge clk);
            rst_n = 1'b1;
            repeat (20) @(posedge clk);
            #1;
            n_chk++; if (cap_vec.size() !== 0) $display("FAIL rstmid%0d_outputs: got %0d want 0", m, cap_vec.size()); else n_pass++;
        end
        clear_caps();
        drive_frame(0, 0, w);
        wait_out(N);
        n_chk++; if (cap_vec.size() !== N) $display("FAIL rstmid_count: got %0d want %0d", cap_vec.size(), N); else n_pass++;
        for (int p = 0; p < N && p < cap_vec.size(); p++) begin
            n_chk++; if (cap_vec[p] !== exp_vec(p)) $display("FAIL rstmid_pix%0d: got %h want %h", p, cap_vec[p], exp_vec(p)); else n_pass++;
            n_chk++; if (cap_cyc[p] !== exp_cyc(0, p)) $display("FAIL rstmid_lat%0d: got cycle %0d want %0d", p, cap_cyc[p], exp_cyc(0, p)); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_peak();
        test_class();
        test_flush_hold();
        test_resync();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
